// File: rtl/countdown_state_controller.sv
// Front-panel countdown sequencer: conditions the push switches, runs the
// one-second prescaler and owns the IDLE/LOADED/RUN/PAUSE/ALARM state machine.
module countdown_state_controller #(
  parameter int TICK_DIV  = 50000000,
  parameter int MAX_SEC   = 999,
  parameter int ALARM_SEC = 5,
  parameter int ADD_SEC   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sw4,
  input  logic       sw5,
  input  logic       sw6,
  input  logic       sw7,
  input  logic [9:0] dipSwitch,
  output logic [2:0] state,
  output logic [9:0] remain,
  output logic       tick,
  output logic [2:0] alarm_left
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]      MAX_R      = 10'(MAX_SEC);
  localparam logic [10:0]     MAX_W      = 11'(MAX_SEC);
  localparam logic [10:0]     ADD_W      = 11'(ADD_SEC);
  localparam logic [2:0]      ALARM_INIT = 3'(ALARM_SEC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    ALARM  = 3'd4
  } state_t;

  state_t        state_reg;
  logic [9:0]    remain_reg;
  logic          tick_reg;
  logic [2:0]    alarm_left_reg;
  logic [PW-1:0] presc_reg;

  // Bit order sw2..sw7 so that press[0] is start and press[5] is acknowledge.
  logic [5:0] sw_raw;
  logic [5:0] press;
  assign sw_raw = {sw7, sw6, sw5, sw4, sw3, sw2};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_cond
      logic sync1_reg;
      logic sync2_reg;
      logic prev_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          prev_reg  <= 1'b0;
        end else begin
          sync1_reg <= sw_raw[gi];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
        end
      end
      assign press[gi] = sync2_reg & ~prev_reg;
    end
  endgenerate

  logic p_start, p_pause, p_clear, p_load, p_add, p_ack;
  assign p_start = press[0];
  assign p_pause = press[1];
  assign p_clear = press[2];
  assign p_load  = press[3];
  assign p_add   = press[4];
  assign p_ack   = press[5];

  logic [9:0]  load_val;
  logic [10:0] sum_add;
  logic [10:0] sum_tick;
  logic [9:0]  add_val;
  logic [9:0]  add_tick_val;
  assign load_val     = (dipSwitch > MAX_R) ? MAX_R : dipSwitch;
  assign sum_add      = {1'b0, remain_reg} + ADD_W;
  assign sum_tick     = sum_add - 11'd1;
  assign add_val      = (sum_add > MAX_W) ? MAX_R : sum_add[9:0];
  assign add_tick_val = (sum_tick > MAX_W) ? MAX_R : sum_tick[9:0];

  logic counting;
  logic wrap;
  logic tick_ev;
  assign counting = (state_reg == RUN) || (state_reg == ALARM);
  assign wrap     = (presc_reg == PRESC_LAST);
  assign tick_ev  = counting && wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      remain_reg     <= '0;
      tick_reg       <= 1'b0;
      alarm_left_reg <= '0;
      presc_reg      <= '0;
    end else begin
      tick_reg <= 1'b0;
      if (counting) begin
        if (wrap) begin
          presc_reg <= '0;
          tick_reg  <= 1'b1;
        end else begin
          presc_reg <= presc_reg + PW'(1);
        end
      end
      // Later assignments below override the free-running prescaler update.
      if (p_clear) begin
        state_reg      <= IDLE;
        remain_reg     <= '0;
        alarm_left_reg <= '0;
        presc_reg      <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (p_load) begin
              remain_reg <= load_val;
              state_reg  <= (load_val != 10'd0) ? LOADED : IDLE;
            end
          end
          LOADED: begin
            if (p_start) begin
              state_reg <= RUN;
              presc_reg <= '0;
            end else if (p_load) begin
              remain_reg <= load_val;
              if (load_val == 10'd0) state_reg <= IDLE;
            end else if (p_add) begin
              remain_reg <= add_val;
            end
          end
          RUN: begin
            if (p_pause) begin
              state_reg <= PAUSE;
            end else if (tick_ev) begin
              if (p_add) begin
                remain_reg <= add_tick_val;
              end else if (remain_reg == 10'd1) begin
                remain_reg     <= '0;
                state_reg      <= ALARM;
                alarm_left_reg <= ALARM_INIT;
                presc_reg      <= '0;
              end else begin
                remain_reg <= remain_reg - 10'd1;
              end
            end else if (p_add) begin
              remain_reg <= add_val;
            end
          end
          PAUSE: begin
            if (p_pause || p_start) begin
              state_reg <= RUN;
            end else if (p_load) begin
              remain_reg <= load_val;
              state_reg  <= (load_val != 10'd0) ? LOADED : IDLE;
              presc_reg  <= '0;
            end else if (p_add) begin
              remain_reg <= add_val;
            end
          end
          ALARM: begin
            if (p_ack) begin
              state_reg      <= IDLE;
              alarm_left_reg <= '0;
              presc_reg      <= '0;
            end else if (tick_ev) begin
              if (alarm_left_reg == 3'd1) begin
                state_reg      <= IDLE;
                alarm_left_reg <= '0;
                presc_reg      <= '0;
              end else begin
                alarm_left_reg <= alarm_left_reg - 3'd1;
              end
            end
          end
          default: begin
            state_reg      <= IDLE;
            remain_reg     <= '0;
            alarm_left_reg <= '0;
            presc_reg      <= '0;
          end
        endcase
      end
    end
  end

  assign state      = state_reg;
  assign remain     = remain_reg;
  assign tick       = tick_reg;
  assign alarm_left = alarm_left_reg;

endmodule

// File: tb/tb_countdown_state_controller.sv
// Directed bench for countdown_state_controller (TICK_DIV=4): stimulus pushes
// cycle-stamped expectations into a scoreboard that a negedge monitor drains.
module tb_countdown_state_controller;

  localparam logic [5:0] SW2 = 6'b000001;
  localparam logic [5:0] SW3 = 6'b000010;
  localparam logic [5:0] SW4 = 6'b000100;
  localparam logic [5:0] SW5 = 6'b001000;
  localparam logic [5:0] SW6 = 6'b010000;
  localparam logic [5:0] SW7 = 6'b100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw2, sw3, sw4, sw5, sw6, sw7;
  logic [9:0] dip;
  logic [2:0] state;
  logic [9:0] remain;
  logic       tick;
  logic [2:0] alarm_left;

  countdown_state_controller #(
    .TICK_DIV(4), .MAX_SEC(999), .ALARM_SEC(5), .ADD_SEC(10)
  ) dut (
    .clk(clk), .rst(rst),
    .sw2(sw2), .sw3(sw3), .sw4(sw4), .sw5(sw5), .sw6(sw6), .sw7(sw7),
    .dipSwitch(dip),
    .state(state), .remain(remain), .tick(tick), .alarm_left(alarm_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          t;
    logic [2:0]  st;
    logic [9:0]  rem;
    logic [2:0]  al;
    logic        tk;
    logic [63:0] nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_at(input int t, input logic [2:0] st, input logic [9:0] rem,
                           input logic [2:0] al, input logic tk, input logic [63:0] nm);
    exp_t e;
    int   i;
    e.t = t; e.st = st; e.rem = rem; e.al = al; e.tk = tk; e.nm = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].t > t) i--;
    sb.insert(i, e);
  endtask

  // Monitor: compare every expectation whose cycle has come up.
  exp_t cur;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].t <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.t != cyc) begin
        errors++;
        $display("FAIL %s slot %0d missed at cycle %0d", cur.nm, cur.t, cyc);
      end else if (state !== cur.st || remain !== cur.rem ||
                   alarm_left !== cur.al || tick !== cur.tk) begin
        errors++;
        $display("FAIL %s cyc %0d: got st=%0d rem=%0d al=%0d tick=%0b, want st=%0d rem=%0d al=%0d tick=%0b",
                 cur.nm, cyc, state, remain, alarm_left, tick, cur.st, cur.rem, cur.al, cur.tk);
      end else begin
        $display("ok   %s cyc %0d st=%0d rem=%0d al=%0d tick=%0b",
                 cur.nm, cyc, state, remain, alarm_left, tick);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  // One-cycle raw pulse; a is the edge at which the press takes effect.
  task automatic pulse(input logic [5:0] m, output int a);
    a = cyc + 3;
    {sw7, sw6, sw5, sw4, sw3, sw2} = m;
    step(1);
    {sw7, sw6, sw5, sw4, sw3, sw2} = 6'd0;
  endtask

  task automatic load(input logic [9:0] v, input logic [2:0] st, input logic [9:0] rem);
    int a;
    dip = v;
    pulse(SW5, a);
    expect_at(a, st, rem, 3'd0, 1'b0, "load");
    step(4);
  endtask

  initial begin
    int a, b, r;
    rst = 1'b1;
    dip = '0;
    {sw7, sw6, sw5, sw4, sw3, sw2} = 6'd0;
    step(1);
    {sw7, sw6, sw5, sw4, sw3, sw2} = 6'h3f;
    dip = 10'h3ff;
    expect_at(2, 3'd0, 10'd0, 3'd0, 1'b0, "rst_hold");
    step(1);
    {sw7, sw6, sw5, sw4, sw3, sw2} = 6'd0;
    rst = 1'b0;
    for (int k = 3; k <= 8; k++) expect_at(k, 3'd0, 10'd0, 3'd0, 1'b0, "rst_idle");

    // Start ignored in IDLE
    pulse(SW2, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "idle_sw2");
    expect_at(a + 1, 3'd0, 10'd0, 3'd0, 1'b0, "idle_sw2");
    step(6);

    // Load clamp, then reload zero from LOADED
    dip = 10'd1023;
    pulse(SW5, a);
    expect_at(a - 1, 3'd0, 10'd0, 3'd0, 1'b0, "ld_early");
    expect_at(a, 3'd1, 10'd999, 3'd0, 1'b0, "ld_clamp");
    step(5);
    dip = 10'd0;
    pulse(SW5, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "reload0");
    step(5);

    // Countdown into ALARM and auto-return
    load(10'd3, 3'd1, 10'd3);
    pulse(SW2, r);
    expect_at(r,      3'd2, 10'd3, 3'd0, 1'b0, "cd_start");
    expect_at(r + 3,  3'd2, 10'd3, 3'd0, 1'b0, "cd_pre");
    expect_at(r + 4,  3'd2, 10'd2, 3'd0, 1'b1, "cd_t1");
    expect_at(r + 5,  3'd2, 10'd2, 3'd0, 1'b0, "cd_t1off");
    expect_at(r + 8,  3'd2, 10'd1, 3'd0, 1'b1, "cd_t2");
    expect_at(r + 12, 3'd4, 10'd0, 3'd5, 1'b1, "cd_alarm");
    expect_at(r + 13, 3'd4, 10'd0, 3'd5, 1'b0, "cd_al5");
    expect_at(r + 16, 3'd4, 10'd0, 3'd4, 1'b1, "cd_al4");
    expect_at(r + 28, 3'd4, 10'd0, 3'd1, 1'b1, "cd_al1");
    expect_at(r + 32, 3'd0, 10'd0, 3'd0, 1'b1, "cd_end");
    expect_at(r + 33, 3'd0, 10'd0, 3'd0, 1'b0, "cd_idle");
    wait_cyc(r + 36);

    // Pause keeps prescaler phase
    load(10'd5, 3'd1, 10'd5);
    pulse(SW2, r);
    expect_at(r, 3'd2, 10'd5, 3'd0, 1'b0, "ps_run");
    expect_at(r + 4, 3'd2, 10'd4, 3'd0, 1'b1, "ps_t1");
    wait_cyc(r + 3);
    pulse(SW3, a);
    expect_at(a, 3'd3, 10'd4, 3'd0, 1'b0, "ps_pause");
    expect_at(a + 20, 3'd3, 10'd4, 3'd0, 1'b0, "ps_frozen");
    wait_cyc(a + 20);
    pulse(SW3, b);
    expect_at(b - 1, 3'd3, 10'd4, 3'd0, 1'b0, "ps_hold");
    expect_at(b,     3'd2, 10'd4, 3'd0, 1'b0, "ps_resume");
    expect_at(b + 1, 3'd2, 10'd4, 3'd0, 1'b0, "ps_phase");
    expect_at(b + 2, 3'd2, 10'd3, 3'd0, 1'b1, "ps_tick");
    expect_at(b + 3, 3'd2, 10'd3, 3'd0, 1'b0, "ps_tkoff");
    wait_cyc(b + 4);
    pulse(SW4, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "ps_clear");
    step(4);

    // Add with saturation in RUN
    load(10'd995, 3'd1, 10'd995);
    pulse(SW2, r);
    wait_cyc(r - 1);
    pulse(SW6, a);
    expect_at(a, 3'd2, 10'd999, 3'd0, 1'b0, "add_sat");
    expect_at(r + 4, 3'd2, 10'd998, 3'd0, 1'b1, "add_dec");
    wait_cyc(r + 6);
    pulse(SW4, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "add_clr");
    step(4);

    // Add coinciding with a tick
    load(10'd4, 3'd1, 10'd4);
    pulse(SW2, r);
    wait_cyc(r + 1);
    pulse(SW6, a);
    expect_at(a, 3'd2, 10'd13, 3'd0, 1'b1, "add_tick");
    expect_at(r + 8, 3'd2, 10'd12, 3'd0, 1'b1, "add_next");
    wait_cyc(r + 10);
    pulse(SW4, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "at_clr");
    step(4);

    // Held sw6 adds once
    load(10'd20, 3'd1, 10'd20);
    a = cyc + 3;
    sw6 = 1'b1;
    expect_at(a, 3'd1, 10'd30, 3'd0, 1'b0, "hold_add");
    expect_at(a + 50, 3'd1, 10'd30, 3'd0, 1'b0, "hold_mid");
    step(100);
    sw6 = 1'b0;
    expect_at(cyc + 5, 3'd1, 10'd30, 3'd0, 1'b0, "hold_end");
    step(6);
    pulse(SW4, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "hold_clr");
    step(4);

    // sw4 and sw7 together in ALARM
    load(10'd1, 3'd1, 10'd1);
    pulse(SW2, r);
    expect_at(r + 4, 3'd4, 10'd0, 3'd5, 1'b1, "pr_alarm");
    wait_cyc(r + 6);
    pulse(SW4 | SW7, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "pr_sw4sw7");
    step(4);

    // sw7 acknowledges ALARM
    load(10'd1, 3'd1, 10'd1);
    pulse(SW2, r);
    expect_at(r + 8, 3'd4, 10'd0, 3'd4, 1'b1, "ack_al4");
    wait_cyc(r + 6);
    pulse(SW7, a);
    expect_at(a, 3'd0, 10'd0, 3'd0, 1'b0, "ack_idle");
    step(4);

    // sw3 and sw2 together in RUN, then reload zero from PAUSE
    load(10'd9, 3'd1, 10'd9);
    pulse(SW2, r);
    wait_cyc(r);
    pulse(SW3 | SW2, a);
    expect_at(a, 3'd3, 10'd9, 3'd0, 1'b0, "pr_pause");
    expect_at(a + 8, 3'd3, 10'd9, 3'd0, 1'b0, "pr_frozen");
    wait_cyc(a + 9);
    dip = 10'd0;
    pulse(SW5, b);
    expect_at(b, 3'd0, 10'd0, 3'd0, 1'b0, "ps_ld0");
    step(6);

    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s slot %0d never checked", cur.nm, cur.t);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/countdown_state_controller.md
Name: countdown_state_controller

Overview:
- Central sequencer for the front-panel countdown timer.
- Converts raw push-switch and DIP-switch inputs into a registered system `state` and a remaining-seconds count.
- Its outputs feed the buzzer, light and 7-segment display controllers, which choose their outputs from `state`.
- Owns all mode sequencing. The downstream controllers hold no state of their own.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick. Set to 4 for simulation.
- MAX_SEC, 999: saturation ceiling for the remaining count, since the display shows 3 digits.
- ALARM_SEC, 5: number of seconds ALARM lasts before auto-returning to IDLE.
- ADD_SEC, 10: seconds added per sw6 press.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sw2  in  1  start (raw, asynchronous, active-high).
- sw3  in  1  pause/resume toggle (raw).
- sw4  in  1  clear to IDLE (raw).
- sw5  in  1  load time from dipSwitch (raw).
- sw6  in  1  add ADD_SEC (raw).
- sw7  in  1  acknowledge/silence alarm (raw).
- dipSwitch  in  10  preset seconds, unsigned. Sampled only on a load.
- state  out  3  IDLE=0, LOADED=1, RUN=2, PAUSE=3, ALARM=4. Codes 5-7 are never produced.
- remain  out  10  remaining seconds, 0..MAX_SEC.
- tick  out  1  one-cycle pulse at each second boundary, in RUN and ALARM only.
- alarm_left  out  3  seconds left in ALARM; 0 outside ALARM.

Behaviour:
- Reset: the synchronous reset `rst` sets these values:
  - state=IDLE, remain=0, tick=0, alarm_left=0;
  - prescaler=0;
  - all synchronizer and edge flops = 0.
- Reset mid-operation overrides every other event in the same cycle.
- Input conditioning:
  - each swN passes through a 2-flop synchronizer plus a previous-value flop;
  - the press pulse is `sync & ~prev`, i.e. one cycle per rising edge; holding a switch produces no repeat;
  - latency: an input that rises before edge k changes `state`/`remain` at edge k+2. All outputs are registered.
- Event priority, when pulses coincide (only the highest acts, except that sw6 may combine with a tick): sw4 > sw7 > sw3 > sw2 > sw5 > sw6.
- Prescaler:
  - counts 0..TICK_DIV-1 while state is RUN or ALARM;
  - tick=1 for the cycle after the counter equals TICK_DIV-1, when it wraps to 0;
  - cleared to 0 on entry to RUN from LOADED and on entry to ALARM;
  - held, not cleared, in PAUSE, so resume keeps the sub-second phase;
  - held at 0 in IDLE and LOADED.
- Load rule: remain <= min(dipSwitch, MAX_SEC), e.g. dip=1023 gives 999.
- Add rule: remain <= min(remain+ADD_SEC, MAX_SEC), using 11-bit intermediate arithmetic.
- Transitions:
  - Any state, on sw4 → IDLE, remain=0, alarm_left=0.
  - IDLE, on sw5 → load. Go to LOADED if the loaded value is nonzero, else stay in IDLE. All other inputs are ignored.
  - LOADED:
    - sw2 → RUN;
    - sw5 → reload; if the value is 0, go to IDLE;
    - sw6 → add.
  - RUN:
    - on tick, remain-1;
    - if a tick arrives with remain==1 → remain=0, ALARM, alarm_left=ALARM_SEC;
    - sw3 → PAUSE;
    - sw6 → add; if it coincides with a tick, remain <= min(remain-1+ADD_SEC, MAX_SEC) and no alarm is raised;
    - sw2 and sw5 are ignored.
  - PAUSE:
    - sw3 or sw2 → RUN;
    - sw5 → reload, then LOADED (or IDLE if 0);
    - sw6 → add;
    - no decrement.
  - ALARM:
    - on each tick, alarm_left-1;
    - a tick with alarm_left==1 → IDLE;
    - sw7 → IDLE immediately;
    - remain stays 0;
    - sw2, sw3, sw5 and sw6 are ignored.
- remain never underflows and never exceeds MAX_SEC. RUN with remain==0 is unreachable.

Test Plan:
- Reset/idle: assert rst for 2 cycles, with switches toggling during reset → state=0, remain=0, tick never asserted. Press sw2 in IDLE → state stays 0.
- Load and clamp: dip=1023, pulse sw5 → state=1 and remain=999, 3 edges after the rise. dip=0, pulse sw5 from LOADED → state=0, remain=0.
- Countdown (TICK_DIV=4): dip=3, sw5, sw2 → tick every 4 cycles; remain goes 2, 1, then 0 with state=4 and alarm_left=5. With no sw7, state=0 after 5 further ticks.
- Pause phase hold: dip=5, run 6 cycles, press sw3 → state=3, remain frozen for 20 cycles. Press sw3 again → the next tick arrives after the remaining phase (2 cycles), not after 4.
- Add and saturation: remain=995 in RUN, press sw6 → 999. remain=4 with sw6 coinciding with a tick → 13.
- Priority: sw4 and sw7 pulse in the same cycle during ALARM → state=0, remain=0. sw3 and sw2 together in RUN → PAUSE. Holding sw6 high for 100 cycles → a single +10.
